// File: rtl/predictive_flow_controller.sv
// Branch/jump redirect resolution with a 2-bit-counter BHT predictor and branch statistics.
// Prediction, redirect and target are combinational (zero latency); BHT/counters update at the clock edge.
// No backpressure: one EX event per cycle is accepted; flush is held by a reloadable down-counter.
module predictive_flow_controller #(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_taken_o,
  input  logic             ex_valid_i,
  input  logic             is_branch_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic             zero_i,
  input  logic             lt_i,
  input  logic             ltu_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  pc_plus4_i,
  input  logic [XLEN-1:0]  pc_imm_target_i,
  input  logic [XLEN-1:0]  alu_target_i,
  output logic             redirect_o,
  output logic             flush_req_o,
  output logic [XLEN-1:0]  final_target_addr_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  // Hold cycles after the redirect cycle itself; zero when FLUSH_CYCLES is 1.
  localparam logic [2:0] HOLD_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;
  logic [2:0]                  hold_q, hold_d;
  logic [CNT_W-1:0]            br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]            mis_cnt_q, mis_cnt_d;

  logic [IDX-1:0] if_idx;
  logic [IDX-1:0] ex_idx;
  logic           actual;
  logic           f3_valid;
  logic           jalr_ev;
  logic           jal_ev;
  logic           br_ev;
  logic           mispred;

  // PC bits outside the word-aligned index field carry no information for the table.
  logic unused_bits;
  assign unused_bits = ^{if_pc_i[XLEN-1:IDX+2], if_pc_i[1:0],
                         ex_pc_i[XLEN-1:IDX+2], ex_pc_i[1:0], alu_target_i[0]};

  assign if_idx = if_pc_i[IDX+1:2];
  assign ex_idx = ex_pc_i[IDX+1:2];

  // Lookup reads the registered table only, so a same-cycle update is not forwarded.
  assign pred_taken_o = bht_q[if_idx][1];

  // Decode branch condition and select the EX event class (JALR > JAL > branch).
  always_comb begin
    actual   = 1'b0;
    f3_valid = 1'b1;
    case (funct3_i)
      3'b000:  actual = zero_i;
      3'b001:  actual = ~zero_i;
      3'b100:  actual = lt_i;
      3'b101:  actual = ~lt_i;
      3'b110:  actual = ltu_i;
      3'b111:  actual = ~ltu_i;
      default: f3_valid = 1'b0;
    endcase
    jalr_ev = ex_valid_i & is_jalr_i;
    jal_ev  = ex_valid_i & is_jal_i & ~is_jalr_i;
    br_ev   = ex_valid_i & is_branch_i & ~is_jal_i & ~is_jalr_i & f3_valid;
    mispred = br_ev & (actual != pred_taken_i);
  end

  // Redirect decision and target mux; the idle target defaults to the branch/JAL target.
  always_comb begin
    redirect_o          = jalr_ev | jal_ev | mispred;
    final_target_addr_o = pc_imm_target_i;
    if (jalr_ev) begin
      final_target_addr_o = {alu_target_i[XLEN-1:1], 1'b0};
    end else if (mispred && !actual) begin
      final_target_addr_o = pc_plus4_i;
    end
  end

  // Flush is immediate on redirect, then held; any new redirect reloads the hold.
  always_comb begin
    hold_d = hold_q;
    if (redirect_o) begin
      hold_d = HOLD_RELOAD;
    end else if (hold_q != 3'd0) begin
      hold_d = hold_q - 3'd1;
    end
    flush_req_o = redirect_o | (hold_q != 3'd0);
  end

  // Train the 2-bit saturating counter of the resolved branch's entry.
  always_comb begin
    bht_d = bht_q;
    if (br_ev) begin
      if (actual && (bht_q[ex_idx] != 2'b11)) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else if (!actual && (bht_q[ex_idx] != 2'b00)) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
  end

  // Saturating statistics counters.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (br_ev && !(&br_cnt_q)) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispred && !(&mis_cnt_q)) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  assign branch_count_o     = br_cnt_q;
  assign mispredict_count_o = mis_cnt_q;

  // State registers; reset makes every entry weakly not-taken and cancels any flush hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bht_q     <= {BHT_ENTRIES{2'b01}};
      hold_q    <= 3'd0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      bht_q     <= bht_d;
      hold_q    <= hold_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_predictive_flow_controller.sv
// Bench for predictive_flow_controller: directed table, hand sequences, randomized traffic
// checked against a plain-arithmetic model (counters as ints, flush as an end-cycle window).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_predictive_flow_controller;
  localparam int XL   = 32;
  localparam int NENT = 64;
  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [XL-1:0] if_pc_i;
  logic          pred_taken_o;
  logic          ex_valid_i, is_branch_i, is_jal_i, is_jalr_i;
  logic [2:0]    funct3_i;
  logic          zero_i, lt_i, ltu_i, pred_taken_i;
  logic [XL-1:0] ex_pc_i, pc_plus4_i, pc_imm_target_i, alu_target_i;
  logic          redirect_o, flush_req_o;
  logic [XL-1:0] final_target_addr_o;
  logic [CW-1:0] branch_count_o, mispredict_count_o;

  predictive_flow_controller #(
    .XLEN(XL), .BHT_ENTRIES(NENT), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i), .pred_taken_o(pred_taken_o),
    .ex_valid_i(ex_valid_i), .is_branch_i(is_branch_i), .is_jal_i(is_jal_i),
    .is_jalr_i(is_jalr_i), .funct3_i(funct3_i), .zero_i(zero_i), .lt_i(lt_i),
    .ltu_i(ltu_i), .pred_taken_i(pred_taken_i), .ex_pc_i(ex_pc_i),
    .pc_plus4_i(pc_plus4_i), .pc_imm_target_i(pc_imm_target_i),
    .alu_target_i(alu_target_i), .redirect_o(redirect_o), .flush_req_o(flush_req_o),
    .final_target_addr_o(final_target_addr_o), .branch_count_o(branch_count_o),
    .mispredict_count_o(mispredict_count_o)
  );

  always #5 clk_i = ~clk_i;

  int nvec  = 0;
  int nfail = 0;

  // Reference model state
  int     m_bht[NENT];
  int     m_br;
  int     m_mis;
  longint cyc;
  longint flush_end;

  typedef struct {
    logic [2:0] f3;
    logic       z, lt, ltu, pred;
    logic       exp_redir;
    logic       exp_plus4;
  } vec_t;
  vec_t tbl[11];

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit f3_ok(input logic [2:0] f);
    return !(f == 3'd2 || f == 3'd3);
  endfunction

  function automatic bit outcome(input logic [2:0] f, input logic z, input logic l, input logic lu);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      3'd7: return !lu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // k: 0 none, 1 branch, 2 jal, 3 jalr
  task automatic compute(output int k, output bit act, output bit mis, output bit er);
    act = outcome(funct3_i, zero_i, lt_i, ltu_i);
    k = 0;
    if (ex_valid_i) begin
      if (is_jalr_i) k = 3;
      else if (is_jal_i) k = 2;
      else if (is_branch_i && f3_ok(funct3_i)) k = 1;
    end
    mis = (k == 1) && (act != pred_taken_i);
    er  = (k >= 2) || mis;
  endtask

  task automatic check_model();
    int k; bit act, mis, er;
    logic [31:0] et;
    compute(k, act, mis, er);
    et = pc_imm_target_i;
    if (k == 3) et = alu_target_i & 32'hFFFF_FFFE;
    else if (mis && !act) et = pc_plus4_i;
    chk("m_redirect", {31'd0, redirect_o}, {31'd0, er});
    chk("m_target", final_target_addr_o, et);
    chk("m_flush", {31'd0, flush_req_o}, {31'd0, (er || (cyc <= flush_end))});
    chk("m_pred", {31'd0, pred_taken_o}, {31'd0, (m_bht[idx_of(if_pc_i)] >= 2)});
    chk("m_branch_count", {28'd0, branch_count_o}, m_br);
    chk("m_mispredict_count", {28'd0, mispredict_count_o}, m_mis);
  endtask

  task automatic model_update();
    int k; bit act, mis, er; int i;
    compute(k, act, mis, er);
    if (rst_i) begin
      foreach (m_bht[j]) m_bht[j] = 1;
      m_br = 0; m_mis = 0; flush_end = -1;
    end else begin
      if (er) flush_end = cyc + FC - 1;
      if (k == 1) begin
        i = idx_of(ex_pc_i);
        m_bht[i] = act ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3) : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
        if (m_br < CMAX) m_br++;
        if (mis && m_mis < CMAX) m_mis++;
      end
    end
    cyc++;
  endtask

  task automatic do_cycle();
    @(negedge clk_i);
    check_model();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    ex_valid_i = 0; is_branch_i = 0; is_jal_i = 0; is_jalr_i = 0;
    funct3_i = 3'd0; zero_i = 0; lt_i = 0; ltu_i = 0; pred_taken_i = 0;
    ex_pc_i = 32'h0; pc_plus4_i = 32'h4; pc_imm_target_i = 32'h40; alu_target_i = 32'h80;
  endtask

  task automatic set_br(input logic [2:0] f, input logic z, input logic l, input logic lu,
                        input logic p, input logic [31:0] pc);
    ex_valid_i = 1; is_branch_i = 1; is_jal_i = 0; is_jalr_i = 0;
    funct3_i = f; zero_i = z; lt_i = l; ltu_i = lu; pred_taken_i = p;
    ex_pc_i = pc; pc_plus4_i = pc + 32'd4; pc_imm_target_i = pc + 32'h1000;
    alu_target_i = 32'hDEAD_BEEF;
  endtask

  initial begin
    tbl = '{
      '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
      '{3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
      '{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}
    };
    foreach (m_bht[j]) m_bht[j] = 1;
    m_br = 0; m_mis = 0; cyc = 0; flush_end = -1;
    set_idle();
    rst_i = 1; if_pc_i = 32'h0;
    @(posedge clk_i); model_update(); #1;
    do_cycle();
    rst_i = 0;

    // Reset state
    if_pc_i = 32'h100; #1;
    chk("rst_branch_count", {28'd0, branch_count_o}, 0);
    chk("rst_mispredict_count", {28'd0, mispredict_count_o}, 0);
    chk("rst_flush", {31'd0, flush_req_o}, 0);
    chk("rst_pred", {31'd0, pred_taken_o}, 0);

    // BEQ taken, predicted not-taken: redirect to target, flush for FC cycles
    set_br(3'd0, 1, 0, 0, 0, 32'h100); #1;
    chk("beq_redirect", {31'd0, redirect_o}, 1);
    chk("beq_target", final_target_addr_o, 32'h1100);
    chk("beq_flush0", {31'd0, flush_req_o}, 1);
    chk("beq_no_bypass", {31'd0, pred_taken_o}, 0);
    do_cycle();
    set_idle(); #1;
    chk("beq_flush1", {31'd0, flush_req_o}, 1);
    chk("beq_mispredict_count", {28'd0, mispredict_count_o}, 1);
    chk("beq_pred_after", {31'd0, pred_taken_o}, 1);
    do_cycle(); #1;
    chk("beq_flush2", {31'd0, flush_req_o}, 1);
    do_cycle(); #1;
    chk("beq_flush3_low", {31'd0, flush_req_o}, 0);

    // Three more taken (saturate at 11), then two not-taken: 11->10 keeps predicting taken
    for (int n = 0; n < 3; n++) begin
      set_br(3'd0, 1, 0, 0, 1, 32'h100); #1;
      chk("sat_no_redirect", {31'd0, redirect_o}, 0);
      do_cycle(); #1;
      chk("sat_pred_taken", {31'd0, pred_taken_o}, 1);
    end
    set_br(3'd0, 0, 0, 0, 0, 32'h100); do_cycle(); #1;
    chk("dec_from_11", {31'd0, pred_taken_o}, 1);
    set_br(3'd0, 0, 0, 0, 0, 32'h100); do_cycle(); #1;
    chk("dec_from_10", {31'd0, pred_taken_o}, 0);
    chk("seq_branch_count", {28'd0, branch_count_o}, 6);
    chk("seq_mispredict_count", {28'd0, mispredict_count_o}, 1);

    // funct3=010 is not a branch
    if_pc_i = 32'h1F0;
    for (int n = 0; n < 2; n++) begin
      set_br(3'd2, 1, 1, 1, 1, 32'h1F0); #1;
      chk("f3_010_redirect", {31'd0, redirect_o}, 0);
      do_cycle();
    end
    set_idle(); #1;
    chk("f3_010_branch_count", {28'd0, branch_count_o}, 6);
    chk("f3_010_pred", {31'd0, pred_taken_o}, 0);

    // JALR clears bit 0; JALR beats JAL; jumps do not train or count
    set_br(3'd0, 1, 0, 0, 0, 32'h1F0); is_jalr_i = 1; alu_target_i = 32'hB00B_1E35; #1;
    chk("jalr_redirect", {31'd0, redirect_o}, 1);
    chk("jalr_target", final_target_addr_o, 32'hB00B_1E34);
    do_cycle();
    set_idle(); ex_valid_i = 1; is_jal_i = 1; is_jalr_i = 1;
    alu_target_i = 32'h1234_5679; pc_imm_target_i = 32'h2000; #1;
    chk("jal_jalr_target", final_target_addr_o, 32'h1234_5678);
    do_cycle();
    set_idle(); ex_valid_i = 1; is_jal_i = 1; pc_imm_target_i = 32'h2000; #1;
    chk("jal_target", final_target_addr_o, 32'h2000);
    do_cycle();
    set_idle(); is_jal_i = 1; is_jalr_i = 1; #1;
    chk("invalid_jump_redirect", {31'd0, redirect_o}, 0);
    do_cycle(); #1;
    chk("jump_branch_count", {28'd0, branch_count_o}, 6);
    chk("jump_pred", {31'd0, pred_taken_o}, 0);

    // Directed branch-condition table
    for (int i = 0; i < 11; i++) begin
      set_br(tbl[i].f3, tbl[i].z, tbl[i].lt, tbl[i].ltu, tbl[i].pred, 32'h400 + 32'(i * 4)); #1;
      chk($sformatf("tbl%0d_redirect", i), {31'd0, redirect_o}, {31'd0, tbl[i].exp_redir});
      chk($sformatf("tbl%0d_target", i), final_target_addr_o,
          (tbl[i].exp_redir && tbl[i].exp_plus4) ? pc_plus4_i : pc_imm_target_i);
      do_cycle();
    end
    // 6 + 9 valid table branches = 15; one more must saturate
    set_br(3'd0, 0, 0, 0, 0, 32'h300); do_cycle(); #1;
    chk("branch_count_saturated", {28'd0, branch_count_o}, 15);

    // Back-to-back redirects with FC=3: flush high 4 continuous cycles
    set_idle(); repeat (FC + 1) do_cycle();
    set_idle(); ex_valid_i = 1; is_jal_i = 1; #1;
    chk("b2b_flush0", {31'd0, flush_req_o}, 1);
    do_cycle(); #1;
    chk("b2b_flush1", {31'd0, flush_req_o}, 1);
    do_cycle();
    set_idle(); #1;
    chk("b2b_flush2", {31'd0, flush_req_o}, 1);
    do_cycle(); #1;
    chk("b2b_flush3", {31'd0, flush_req_o}, 1);
    do_cycle(); #1;
    chk("b2b_flush4_low", {31'd0, flush_req_o}, 0);

    // Reset in the middle of a hold cancels it
    ex_valid_i = 1; is_jal_i = 1; do_cycle();
    set_idle(); rst_i = 1; #1;
    chk("rst_mid_hold_before", {31'd0, flush_req_o}, 1);
    do_cycle();
    rst_i = 0; #1;
    chk("rst_mid_hold_after", {31'd0, flush_req_o}, 0);
    chk("rst_mid_branch_count", {28'd0, branch_count_o}, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_i        = ($urandom_range(0, 39) == 0);
      ex_valid_i   = ($urandom_range(0, 4) != 0);
      is_branch_i  = ($urandom_range(0, 2) != 0);
      is_jal_i     = ($urandom_range(0, 7) == 0);
      is_jalr_i    = ($urandom_range(0, 7) == 0);
      funct3_i     = 3'($urandom);
      zero_i       = 1'($urandom); lt_i = 1'($urandom); ltu_i = 1'($urandom);
      pred_taken_i = 1'($urandom);
      ex_pc_i      = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      if_pc_i      = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      pc_plus4_i   = ex_pc_i + 32'd4;
      pc_imm_target_i = $urandom;
      alu_target_i = $urandom;
      do_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/predictive_flow_controller.md
PREDICTIVE_FLOW_CONTROLLER -- requirements
Module: predictive_flow_controller

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, giving the address/data width.
REQ-002 The block SHALL have parameter BHT_ENTRIES, default 64, giving the branch-history-table depth; it must be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..4, giving the total cycles flush_req_o stays high per redirect.
REQ-004 The block SHALL have parameter CNT_W, default 32, giving the statistics counter width.

Interface
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 if_pc_i  in  XLEN  fetch-stage PC used for prediction lookup.
REQ-008 pred_taken_o  out  1  fetch-stage prediction, combinational from the BHT.
REQ-009 ex_valid_i  in  1  EX-stage instruction valid.
REQ-010 is_branch_i / is_jal_i / is_jalr_i  in  1 each  EX instruction class.
REQ-011 funct3_i  in  3  branch condition select.
REQ-012 zero_i / lt_i / ltu_i  in  1 each  ALU flags: equal, signed-less, unsigned-less.
REQ-013 pred_taken_i  in  1  prediction that was made for this EX instruction at fetch.
REQ-014 ex_pc_i / pc_plus4_i / pc_imm_target_i / alu_target_i  in  XLEN each  EX PC, fall-through PC, branch/JAL target, JALR target.
REQ-015 redirect_o  out  1  PC must load final_target_addr_o.
REQ-016 flush_req_o  out  1  flush the younger pipeline stages.
REQ-017 final_target_addr_o  out  XLEN  redirect address.
REQ-018 branch_count_o / mispredict_count_o  out  CNT_W each  statistics counters.

Function
REQ-019 The BHT index SHALL be pc[IDX+1:2] with IDX=log2(BHT_ENTRIES); entries SHALL be 2-bit saturating counters, and pred_taken_o SHALL equal bit 1 of the entry indexed by if_pc_i.
REQ-020 The actual branch outcome SHALL be: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010 and 011 SHALL be treated as not-taken and as not a valid branch.
REQ-021 The EX event class SHALL be chosen only when ex_valid_i=1, with priority JALR > JAL > valid branch; if ex_valid_i=0, all EX effects SHALL be suppressed.
REQ-022 JAL SHALL assert redirect_o with target pc_imm_target_i; JALR SHALL assert redirect_o with target alu_target_i with bit 0 cleared.
REQ-023 A valid branch SHALL assert redirect_o only on mispredict (actual != pred_taken_i); the target SHALL be pc_imm_target_i if actual=1, else pc_plus4_i.
REQ-024 When redirect_o=0, final_target_addr_o SHALL equal pc_imm_target_i.
REQ-025 redirect_o and final_target_addr_o SHALL be combinational, valid in the same cycle as the EX inputs (zero latency).
REQ-026 flush_req_o SHALL be high combinationally in each redirect cycle, then held by a registered down-counter for FLUSH_CYCLES-1 further cycles; a new redirect during the hold SHALL reload the counter; FLUSH_CYCLES=1 means no hold.
REQ-027 On each valid branch, the indexed BHT entry (index from ex_pc_i) SHALL increment if actual=1 and decrement if actual=0, saturating at 11 and 00; jumps, invalid funct3 and ex_valid_i=0 SHALL NOT update the BHT.
REQ-028 A lookup and an update to the same index in the same cycle SHALL return the pre-update value (no bypass).
REQ-029 branch_count_o SHALL increment on each valid branch, and mispredict_count_o on each branch mispredict; both SHALL saturate at all-ones.

Reset
REQ-030 While rst_i=1 at a clock edge, every BHT entry SHALL become 01 (weakly not-taken), the flush hold counter SHALL become 0, and both statistics counters SHALL become 0.
REQ-031 During reset the combinational outputs SHALL still follow their inputs; the flush hold SHALL be cancelled even if reset arrives mid-hold.

Verification
REQ-032 After reset, BEQ at ex_pc_i=0x100 with zero_i=1 and pred_taken_i=0 -> redirect_o=1, target=pc_imm_target_i, flush high 2 cycles, mispredict_count_o=1.
REQ-033 Same BEQ taken three times -> entry goes 01->10->11->11; pred_taken_o=1 for if_pc_i=0x100 after the first update.
REQ-034 BLTU, pred_taken_i=1, ltu_i=0 -> redirect to pc_plus4_i; BGE, pred_taken_i=0, lt_i=1 -> no redirect, no flush.
REQ-035 JALR with alu_target_i=0xB00B1E35 -> target 0xB00B1E34, no BHT or statistics change; JAL together with JALR asserted -> the JALR target wins.
REQ-036 Redirect, then a second redirect one cycle later (FLUSH_CYCLES=3) -> flush high 4 continuous cycles; rst_i asserted mid-hold -> flush low the next cycle.
REQ-037 funct3=010 with is_branch_i=1 -> no redirect, no update, branch_count_o unchanged.
